// File: rtl/process_scheduler.sv
// Round-robin preemptive process scheduler: tracks ready PIDs and saved PCs,
// picks the next process and hands its resume PC to the CPU via req/ack.
module process_scheduler #(
    parameter int unsigned NUM_PROC    = 10,
    parameter int unsigned PID_WIDTH   = 4,
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned BASE_OFFSET = 1,
    parameter int unsigned PART_SIZE   = 100,
    parameter int unsigned QUANTUM     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  preempt_en,
    input  logic                  create_req,
    input  logic [PID_WIDTH-1:0]  create_pid,
    input  logic                  exit_req,
    input  logic                  tick,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    input  logic                  switch_ack,
    output logic                  switch_req,
    output logic [ADDR_WIDTH-1:0] next_pc,
    output logic [PID_WIDTH-1:0]  next_pid,
    output logic [PID_WIDTH-1:0]  cur_pid,
    output logic                  running,
    output logic                  idle,
    output logic [NUM_PROC-1:0]   ready_mask
);

    localparam int unsigned QW = $clog2(QUANTUM + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SELECT = 2'd1,
        S_SWITCH = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [NUM_PROC-1:0]   r_ready;
    logic [ADDR_WIDTH-1:0] r_saved_pc [NUM_PROC];
    logic [PID_WIDTH-1:0]  r_cur_pid;
    logic [PID_WIDTH-1:0]  r_next_pid;
    logic [ADDR_WIDTH-1:0] r_next_pc;
    logic [QW-1:0]         r_quantum;

    logic                  w_exit;
    logic                  w_expire;
    logic                  w_create_ok;
    logic                  w_sel_found;
    logic [PID_WIDTH-1:0]  w_sel_pid;

    function automatic logic [ADDR_WIDTH-1:0] f_base(input logic [PID_WIDTH-1:0] pid);
        return ADDR_WIDTH'(BASE_OFFSET + 32'(pid) * PART_SIZE);
    endfunction

    assign w_exit   = (r_state == S_RUN) && exit_req;
    assign w_expire = (r_state == S_RUN) && preempt_en && tick && (r_quantum == QW'(1));
    // A create of the PID that is exiting this cycle counts as a fresh create.
    assign w_create_ok = create_req && (32'(create_pid) < NUM_PROC) &&
                         (!r_ready[create_pid] || (w_exit && (create_pid == r_cur_pid)));

    // Rotating search from cur_pid+1; cur_pid itself is examined last.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_pid   = '0;
        for (int unsigned k = NUM_PROC; k >= 1; k--) begin
            if (r_ready[PID_WIDTH'((32'(r_cur_pid) + k) % NUM_PROC)]) begin
                w_sel_found = 1'b1;
                w_sel_pid   = PID_WIDTH'((32'(r_cur_pid) + k) % NUM_PROC);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:   if (r_ready != '0) w_state_next = S_SELECT;
            S_SELECT: w_state_next = w_sel_found ? S_SWITCH : S_IDLE;
            S_SWITCH: if (switch_ack) w_state_next = S_RUN;
            S_RUN:    if (w_exit || w_expire) w_state_next = S_SELECT;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        switch_req = 1'b0;
        running    = 1'b0;
        idle       = 1'b0;
        unique case (r_state)
            S_IDLE:   idle       = 1'b1;
            S_SWITCH: switch_req = 1'b1;
            S_RUN:    running    = 1'b1;
            default:  ;
        endcase
    end

    // Ready set, saved PCs, selection latches and the time-slice counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ready    <= '0;
            r_cur_pid  <= '0;
            r_next_pid <= '0;
            r_next_pc  <= '0;
            r_quantum  <= QW'(QUANTUM);
            for (int unsigned i = 0; i < NUM_PROC; i++) begin
                r_saved_pc[i] <= f_base(PID_WIDTH'(i));
            end
        end else begin
            if (w_exit) begin
                r_ready[r_cur_pid]    <= 1'b0;
                r_saved_pc[r_cur_pid] <= f_base(r_cur_pid);
            end else if (w_expire) begin
                r_saved_pc[r_cur_pid] <= pc_in;
            end
            if (w_create_ok) begin
                r_ready[create_pid]    <= 1'b1;
                r_saved_pc[create_pid] <= f_base(create_pid);
            end
            if ((r_state == S_SELECT) && w_sel_found) begin
                r_next_pid <= w_sel_pid;
                r_next_pc  <= r_saved_pc[w_sel_pid];
            end
            if ((r_state == S_SWITCH) && switch_ack) begin
                r_cur_pid <= r_next_pid;
                r_quantum <= QW'(QUANTUM);
            end else if ((r_state == S_RUN) && preempt_en && tick && !exit_req &&
                         (r_quantum != '0)) begin
                r_quantum <= r_quantum - QW'(1);
            end
        end
    end

    assign next_pc    = r_next_pc;
    assign next_pid   = r_next_pid;
    assign cur_pid    = r_cur_pid;
    assign ready_mask = r_ready;

endmodule

// File: tb/tb_process_scheduler.sv
// Directed self-checking bench for process_scheduler (QUANTUM = 4).
module tb_process_scheduler;

    localparam int unsigned NP = 10;
    localparam int unsigned PW = 4;
    localparam int unsigned AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          preempt_en;
    logic          create_req;
    logic [PW-1:0] create_pid;
    logic          exit_req;
    logic          tick;
    logic [AW-1:0] pc_in;
    logic          switch_ack;
    logic          switch_req;
    logic [AW-1:0] next_pc;
    logic [PW-1:0] next_pid;
    logic [PW-1:0] cur_pid;
    logic          running;
    logic          idle;
    logic [NP-1:0] ready_mask;

    int n_checks = 0;
    int n_errors = 0;

    process_scheduler #(
        .NUM_PROC(NP), .PID_WIDTH(PW), .ADDR_WIDTH(AW),
        .BASE_OFFSET(1), .PART_SIZE(100), .QUANTUM(4)
    ) dut (
        .clk(clk), .rst(rst), .preempt_en(preempt_en),
        .create_req(create_req), .create_pid(create_pid),
        .exit_req(exit_req), .tick(tick), .pc_in(pc_in),
        .switch_ack(switch_ack), .switch_req(switch_req),
        .next_pc(next_pc), .next_pid(next_pid), .cur_pid(cur_pid),
        .running(running), .idle(idle), .ready_mask(ready_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!switch_req && n < 20) begin
            step();
            n++;
        end
        check(tag, 32'(switch_req), 32'd1);
    endtask

    task automatic ack();
        switch_ack = 1'b1;
        step();
        switch_ack = 1'b0;
    endtask

    task automatic create(input int unsigned pid);
        create_req = 1'b1;
        create_pid = PW'(pid);
        step();
        create_req = 1'b0;
    endtask

    task automatic do_exit();
        exit_req = 1'b1;
        step();
        exit_req = 1'b0;
    endtask

    // n consecutive ticks; only the final one carries pc_last
    task automatic do_ticks(input int n, input int unsigned pc_last);
        for (int i = 0; i < n; i++) begin
            tick  = 1'b1;
            pc_in = (i == n - 1) ? AW'(pc_last) : AW'(pc_last - 1);
            step();
        end
        tick = 1'b0;
    endtask

    initial begin
        int seen;
        rst = 1'b1; preempt_en = 1'b1; create_req = 1'b0; create_pid = '0;
        exit_req = 1'b0; tick = 1'b0; pc_in = '0; switch_ack = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        check("rst_idle",    32'(idle),       32'd1);
        check("rst_running", 32'(running),    32'd0);
        check("rst_req",     32'(switch_req), 32'd0);
        check("rst_ready",   32'(ready_mask), 32'd0);
        check("rst_cur",     32'(cur_pid),    32'd0);
        check("rst_next_pc", 32'(next_pc),    32'd0);

        // create 2 and 5, first selection
        create(2);
        create(5);
        wait_req("sel_req");
        check("sel_pid",   32'(next_pid),   32'd2);
        check("sel_pc",    32'(next_pc),    32'd201);
        check("sel_ready", 32'(ready_mask), 32'h024);
        ack();
        check("ack_run", 32'(running),    32'd1);
        check("ack_cur", 32'(cur_pid),    32'd2);
        check("ack_req", 32'(switch_req), 32'd0);

        // quantum expiry round trip
        do_ticks(3, 204);
        check("q3_noreq", 32'(switch_req), 32'd0);
        check("q3_run",   32'(running),    32'd1);
        do_ticks(1, 205);
        wait_req("q_req");
        check("q_pid", 32'(next_pid), 32'd5);
        check("q_pc",  32'(next_pc),  32'd501);
        ack();
        check("q_cur5", 32'(cur_pid), 32'd5);
        do_ticks(4, 504);
        wait_req("q2_req");
        check("q2_pid", 32'(next_pid), 32'd2);
        check("q2_pc",  32'(next_pc),  32'd205);
        ack();

        // non-preemptive run, then exits until idle
        preempt_en = 1'b0;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            tick = 1'b1;
            pc_in = AW'(300 + i);
            step();
            if (switch_req) seen = 1;
        end
        tick = 1'b0;
        check("np_noreq", 32'(seen),    32'd0);
        check("np_run",   32'(running), 32'd1);
        do_exit();
        wait_req("np_exit_req");
        check("np_exit_ready", 32'(ready_mask), 32'h020);
        check("np_exit_pid",   32'(next_pid),   32'd5);
        check("np_exit_pc",    32'(next_pc),    32'd504);
        ack();
        do_exit();
        step(); step(); step();
        check("np_idle",  32'(idle),       32'd1);
        check("np_empty", 32'(ready_mask), 32'd0);
        check("np_noreq2", 32'(switch_req), 32'd0);

        // wrap-around from PID 9 to PID 0
        preempt_en = 1'b1;
        create(9);
        create(0);
        wait_req("w_req");
        check("w_pid9", 32'(next_pid), 32'd9);
        check("w_pc9",  32'(next_pc),  32'd901);
        ack();
        do_ticks(4, 950);
        wait_req("w_req0");
        check("w_pid0", 32'(next_pid), 32'd0);
        check("w_pc0",  32'(next_pc),  32'd1);
        ack();
        do_exit();
        wait_req("w_req9b");
        check("w_pc9b", 32'(next_pc), 32'd950);
        ack();

        // sole ready process reselects itself
        create(3);
        do_exit();
        wait_req("s_req");
        check("s_pid", 32'(next_pid), 32'd3);
        check("s_pc",  32'(next_pc),  32'd301);
        ack();
        do_ticks(4, 333);
        wait_req("s_req2");
        check("s_pid2", 32'(next_pid), 32'd3);
        check("s_pc2",  32'(next_pc),  32'd333);
        ack();

        // ignored creates, then exit colliding with the expiring tick
        create_req = 1'b1; create_pid = PW'(3); tick = 1'b1; pc_in = AW'(340);
        step();
        create_pid = PW'(12); pc_in = AW'(341);
        step();
        create_req = 1'b0; pc_in = AW'(342);
        step();
        check("c_ign_ready", 32'(ready_mask), 32'h008);
        check("c_ign_run",   32'(running),    32'd1);
        exit_req = 1'b1; pc_in = AW'(344);
        step();
        tick = 1'b0; exit_req = 1'b0;
        step(); step(); step();
        check("ex_win_idle",  32'(idle),       32'd1);
        check("ex_win_ready", 32'(ready_mask), 32'd0);
        create(3);
        wait_req("ex_re_req");
        check("ex_re_pc", 32'(next_pc), 32'd301);
        ack();

        // stray ack in RUN
        ack();
        check("sa_run", 32'(running),    32'd1);
        check("sa_req", 32'(switch_req), 32'd0);
        check("sa_cur", 32'(cur_pid),    32'd3);

        // create of the exiting PID wins
        do_ticks(2, 361);
        create_req = 1'b1; create_pid = PW'(3); exit_req = 1'b1;
        step();
        create_req = 1'b0; exit_req = 1'b0;
        check("ce_ready", 32'(ready_mask), 32'h008);
        wait_req("ce_req");
        check("ce_pid", 32'(next_pid), 32'd3);
        check("ce_pc",  32'(next_pc),  32'd301);
        ack();

        // exit of 3 together with create of 7, then reset mid-handshake
        create_req = 1'b1; create_pid = PW'(7); exit_req = 1'b1;
        step();
        create_req = 1'b0; exit_req = 1'b0;
        check("cx_ready", 32'(ready_mask), 32'h080);
        wait_req("cx_req");
        check("cx_pid", 32'(next_pid), 32'd7);
        check("cx_pc",  32'(next_pc),  32'd701);
        #2;
        rst = 1'b1;
        #1;
        check("ar_req",   32'(switch_req), 32'd0);
        check("ar_run",   32'(running),    32'd0);
        check("ar_ready", 32'(ready_mask), 32'd0);
        check("ar_idle",  32'(idle),       32'd1);
        step();
        rst = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/process_scheduler.md
Name: process_scheduler

Overview:
- Round-robin preemptive process scheduler for the instruction memory's process partitions.
- Tracks ready processes and each process's saved PC.
- Decides when the running process loses the CPU and hands the processor the resume PC of the next process via a req/ack handshake.
- Sits between the processor's context-switch logic and the fetch path; replaces the software-only selection in the OS partitions.

Parameters:
- NUM_PROC, 10, number of process partitions (PIDs 0..NUM_PROC-1).
- PID_WIDTH, 4, width of PID fields; must satisfy 2**PID_WIDTH >= NUM_PROC.
- ADDR_WIDTH, 12, instruction address width.
- BASE_OFFSET, 1, ROM address of partition 0.
- PART_SIZE, 100, words per partition; base(pid) = BASE_OFFSET + pid*PART_SIZE.
- QUANTUM, 32, ticks per time slice.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- preempt_en  in  1  1 = time-sliced; 0 = run until exit.
- create_req  in  1  one-cycle pulse: mark create_pid ready.
- create_pid  in  PID_WIDTH  process to create.
- exit_req  in  1  one-cycle pulse: running process terminates.
- tick  in  1  one instruction retired by the running process.
- pc_in  in  ADDR_WIDTH  processor PC of the running process; valid while tick or exit_req is high.
- switch_ack  in  1  processor finished loading next_pc.
- switch_req  out  1  context switch requested.
- next_pc  out  ADDR_WIDTH  resume PC of the incoming process.
- next_pid  out  PID_WIDTH  incoming process.
- cur_pid  out  PID_WIDTH  running process.
- running  out  1  a process owns the CPU.
- idle  out  1  no process ready.
- ready_mask  out  NUM_PROC  ready flag per PID.

Behaviour:
- Reset values:
  - ready_mask = 0, every saved_pc[i] = base(i).
  - cur_pid = 0, next_pid = 0, next_pc = 0.
  - switch_req = 0, running = 0, idle = 1.
  - quantum counter = QUANTUM, state = IDLE.
- Reset mid-handshake drops switch_req immediately; the processor must discard any pending switch.
- States:
  - IDLE: idle = 1, running = 0. If ready_mask != 0 on an edge, go to SELECT.
  - SELECT (exactly one cycle):
    - Rotating search starts at (cur_pid+1) mod NUM_PROC and wraps; the first ready PID wins.
    - cur_pid itself is the last candidate, so a sole ready process reselects itself.
    - Latch next_pid and next_pc = saved_pc[next_pid]; go to SWITCH.
    - If ready_mask == 0 (e.g. cleared the same cycle), go to IDLE instead.
  - SWITCH:
    - switch_req = 1; next_pc and next_pid stay stable until ack.
    - On switch_ack: cur_pid <= next_pid, quantum <= QUANTUM, switch_req <= 0, go to RUN.
    - switch_ack outside SWITCH is ignored.
  - RUN: running = 1.
    - With preempt_en = 1: each tick decrements quantum. A tick while quantum == 1 does saved_pc[cur_pid] <= pc_in and goes to SELECT.
    - With preempt_en = 0: ticks are ignored and the quantum is held.
    - exit_req: ready[cur_pid] <= 0, saved_pc[cur_pid] <= base(cur_pid), go to SELECT. exit_req has priority over a same-cycle quantum expiry.
    - tick and exit_req outside RUN are ignored.
- Switch latency: expiry or exit edge -> SELECT (1 cycle) -> switch_req high on the following cycle; minimum 2 cycles to switch_req.
- create_req:
  - Accepted in any state: ready[create_pid] <= 1, saved_pc[create_pid] <= base(create_pid).
  - Ignored if create_pid >= NUM_PROC or the PID is already ready (its saved PC is preserved).
  - A create in the same cycle as an exit of a different PID applies both.
  - A create of the exiting PID in the same cycle: the create wins and the PID stays ready with PC = base.
- Saved PC, base and next_pc are ADDR_WIDTH wide and unsigned. base(pid) is computed with constant arithmetic and must not exceed 2**ADDR_WIDTH-1.

Test Plan:
- Reset mid-SWITCH: assert rst while switch_req = 1 -> switch_req, running and ready_mask go to 0 asynchronously without a clock edge; idle = 1.
- Create and select: create PIDs 2 and 5 from IDLE -> switch_req with next_pid = 2, next_pc = 201. Ack -> running = 1, cur_pid = 2.
- Quantum expiry (QUANTUM = 4, preempt_en = 1), PID 2 running: tick ×4 with pc_in = 205 on the 4th -> switch_req with next_pid = 5, next_pc = 501. After PID 5 exhausts its quantum -> next_pid = 2, next_pc = 205.
- Non-preemptive: preempt_en = 0, 50 ticks -> no switch_req. Then exit_req -> ready[cur] = 0 and the next ready PID is selected. With no PID left -> idle = 1.
- Wrap-around: PIDs 9 and 0 ready, PID 9 running, quantum expires -> next_pid = 0, next_pc = 1. Sole-ready case: PID 3 alone, expiry -> reselects PID 3 with the saved pc_in value.
- Simultaneous events:
  - exit_req and the last tick in the same cycle -> exit wins and saved_pc = base.
  - Create of the running PID -> ignored.
  - create_pid = 12 -> ignored.
  - switch_ack while in RUN -> no effect.
